// File: rtl/fft_pkg.sv
// fft_pkg: shared types and defaults for the FFT address scheduler.
// Holds the FSM state enum, the default transform geometry and the helper
// that sizes the stage counter.
package fft_pkg;

    localparam int FFT_N_PTS  = 64;
    localparam int FFT_LOG2_N = 6;
    localparam int FFT_BF_LAT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fft_state_t;

    // Width of the stage number; never narrower than one bit.
    function automatic int stage_width(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/fft_sched_wb_pipe.sv
// fft_sched_wb_pipe: LAT-deep shift register carrying the issue strobe and
// the butterfly pair addresses forward to writeback.
// en freezes the line in place; flush clears every slot so in-flight
// writebacks are squashed. Updates on the falling clock edge.
module fft_sched_wb_pipe #(
    parameter int LAT = 2,
    parameter int AW  = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          v_in,
    input  logic [AW-1:0] a_in,
    input  logic [AW-1:0] b_in,
    output logic          v_out,
    output logic [AW-1:0] a_out,
    output logic [AW-1:0] b_out
);

    logic [LAT-1:0]         v_q;
    logic [LAT-1:0][AW-1:0] a_q;
    logic [LAT-1:0][AW-1:0] b_q;

    // Shift valid and addresses one slot per enabled cycle; flush empties the line.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (flush) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (en) begin
            v_q[0] <= v_in;
            a_q[0] <= a_in;
            b_q[0] <= b_in;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

    assign v_out = v_q[LAT-1];
    assign a_out = a_q[LAT-1];
    assign b_out = b_q[LAT-1];

endmodule

// File: rtl/fft_scheduler.sv
// fft_scheduler: radix-2 in-place FFT address sequencer.
// Issues one butterfly read per cycle for each of LOG2_N stages, inserts a
// BF_LAT-cycle drain between stages so the next stage never reads a word
// before its last writeback, and replays the read addresses as writeback
// addresses BF_LAT cycles later through fft_sched_wb_pipe.
// All state updates on the falling clock edge; rst is async active-low.
// Optional build macro FFT_SCHED_HOLD_EN adds a hold input that freezes
// the pass while in RUN or DRAIN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet, indices keep last values
// RUN   | one butterfly issued per cycle, k = 0 .. N_PTS/2-1
// DRAIN | no reads for BF_LAT cycles while the stage's last writes land
// DONE  | one cycle after the final drain; done pulses on the exit edge
module fft_scheduler
    import fft_pkg::*;
#(
    parameter int N_PTS  = FFT_N_PTS,
    parameter int LOG2_N = FFT_LOG2_N,
    parameter int BF_LAT = FFT_BF_LAT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
`ifdef FFT_SCHED_HOLD_EN
    input  logic                             hold,
`endif
    output logic                             busy,
    output logic                             done,
    output logic [stage_width(LOG2_N)-1:0]   stage,
    output logic                             rd_en,
    output logic [LOG2_N-1:0]                idx_a,
    output logic [LOG2_N-1:0]                idx_b,
    output logic [LOG2_N-2:0]                tw_idx,
    output logic                             wr_en,
    output logic [LOG2_N-1:0]                wr_idx_a,
    output logic [LOG2_N-1:0]                wr_idx_b
);

    localparam int AW = LOG2_N;
    localparam int KW = LOG2_N - 1;
    localparam int SW = stage_width(LOG2_N);

    fft_state_t      state_q;
    logic [KW-1:0]   k_q;
    logic [SW-1:0]   s_q;
    logic [2:0]      dcnt_q;
    logic            busy_q;
    logic            done_q;
    logic            rd_en_q;
    logic            hold_q;
    logic [AW-1:0]   idx_a_q;
    logic [AW-1:0]   idx_b_q;
    logic [KW-1:0]   tw_q;

    logic            frozen;
    logic [KW-1:0]   nk;
    logic [SW-1:0]   ns;
    logic [AW-1:0]   kk;
    logic [AW-1:0]   mask;
    logic [AW-1:0]   ca;
    logic [AW-1:0]   cb;
    logic [KW-1:0]   ctw;
    int              sh;

    logic            pipe_v;
    logic [AW-1:0]   pipe_a;
    logic [AW-1:0]   pipe_b;

`ifdef FFT_SCHED_HOLD_EN
    assign frozen = hold && ((state_q == S_RUN) || (state_q == S_DRAIN));
`else
    assign frozen = 1'b0;
`endif

    // Select the butterfly that would be issued at the next edge.
    always_comb begin
        nk = '0;
        ns = '0;
        if (state_q == S_RUN) begin
            nk = k_q + 1'b1;
            ns = s_q;
        end else if (state_q == S_DRAIN) begin
            nk = '0;
            ns = s_q + 1'b1;
        end
    end

    // Pair addresses and twiddle index for butterfly nk of stage ns.
    // idx_a has a zero at bit ns, so adding the half-span sets that bit.
    always_comb begin
        sh   = int'(ns);
        kk   = {1'b0, nk};
        mask = (AW'(1) << sh) - AW'(1);
        ca   = ((kk >> sh) << (sh + 1)) + (kk & mask);
        cb   = ca + (AW'(1) << sh);
        ctw  = KW'((kk & mask) << (KW - sh));
    end

    // Sequencer FSM with registered strobes; abort beats everything but reset.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            hold_q  <= 1'b0;
            idx_a_q <= '0;
            idx_b_q <= '0;
            tw_q    <= '0;
        end else if (abort) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            hold_q <= frozen;
            if (!frozen) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            k_q     <= '0;
                            s_q     <= '0;
                            rd_en_q <= 1'b1;
                            idx_a_q <= ca;
                            idx_b_q <= cb;
                            tw_q    <= ctw;
                        end
                    end
                    S_RUN: begin
                        if (k_q == KW'(N_PTS / 2 - 1)) begin
                            state_q <= S_DRAIN;
                            rd_en_q <= 1'b0;
                            dcnt_q  <= 3'(BF_LAT - 1);
                        end else begin
                            k_q     <= nk;
                            rd_en_q <= 1'b1;
                            idx_a_q <= ca;
                            idx_b_q <= cb;
                            tw_q    <= ctw;
                        end
                    end
                    S_DRAIN: begin
                        if (dcnt_q == 3'd0) begin
                            if (s_q == SW'(LOG2_N - 1)) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_RUN;
                                s_q     <= ns;
                                k_q     <= '0;
                                rd_en_q <= 1'b1;
                                idx_a_q <= ca;
                                idx_b_q <= cb;
                                tw_q    <= ctw;
                            end
                        end else begin
                            dcnt_q <= dcnt_q - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        s_q     <= '0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // The delay line is fed from the registered read strobe, so writeback
    // trails the visible read by exactly BF_LAT advancing cycles.
    fft_sched_wb_pipe #(
        .LAT (BF_LAT),
        .AW  (AW)
    ) u_wb_pipe (
        .clk   (clk),
        .rst   (rst),
        .en    (!frozen),
        .flush (abort),
        .v_in  (rd_en_q),
        .a_in  (idx_a_q),
        .b_in  (idx_b_q),
        .v_out (pipe_v),
        .a_out (pipe_a),
        .b_out (pipe_b)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign stage    = s_q;
    assign rd_en    = rd_en_q & ~hold_q;
    assign idx_a    = idx_a_q;
    assign idx_b    = idx_b_q;
    assign tw_idx   = tw_q;
    assign wr_en    = pipe_v & ~hold_q;
    assign wr_idx_a = pipe_a;
    assign wr_idx_b = pipe_b;

endmodule
